regfile_gen2: RTL and testbench
===============================

# regfile_gen2

Parametrised second-generation register file for the processor datapath: `2**D` registers of `W` bits with `NR` combinational read ports and one write port. Features:

- A two-phase load (`RegSet`) state machine.
- A shift-pair mode.
- A bit-masked protected register.
- Optional write-to-read bypass.
- A bank of `NF` sticky status flags.

It sits between the decoder/ALU and the data memory, replacing the fixed 8x16, two-port file.

## Interface
Parameters:
- `W`, 8, register width in bits.
- `D`, 4, address width; depth is `2**D`.
- `NR`, 2, number of read ports (must be 2 or more).
- `NF`, 1, number of status flags.
- `PAIR_LO`, 6, shift-pair low register address.
- `PAIR_HI`, 7, shift-pair high register address.
- `PROT_ADDR`, 7, address of the protected register.
- `PROT_MASK`, `{1'b0,{W-1{1'b1}}}`, writable-bit mask for `PROT_ADDR`.
- `BYPASS`, 0, set to 1 to forward the same-cycle write to the read ports.

Ports:
- `Clk`  in  1  single clock, rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Start`  in  1  synchronous clear of all registers, flags and the state machine.
- `RegSet`  in  1  arm a load; the target is `Raddr` port 1.
- `WriteEn`  in  1  normal write strobe.
- `Shift`  in  1  shift-pair mode.
- `FlagSet`  in  NF  per-flag set.
- `FlagClr`  in  NF  per-flag clear.
- `Raddr`  in  NR*D  packed read addresses; port i is at `[i*D +: D]`.
- `Waddr`  in  D  write address.
- `DataIn`  in  W  write data.
- `IsLoadingReg`  out  1  high while in `ARMED`.
- `Flags`  out  NF  sticky flag state.
- `DataOut`  out  NR*W  packed read data.

## Operation
State machine, states `IDLE` and `ARMED`:
- `IDLE` to `ARMED` on `RegSet`. Latch `LoadReg <= Raddr[1]`, or `PAIR_HI` if `Shift` is high.
- `ARMED` to `IDLE` on the next edge. That edge writes `DataIn` to `LoadReg` regardless of `WriteEn`, and clears every flag not set that cycle.
- `ARMED` with `RegSet` high: complete the current load, latch the new target, and stay in `ARMED`.

Write address, in priority order:
1. `PAIR_HI` if `Shift` is high.
2. `LoadReg` if in `ARMED`.
3. `Waddr` otherwise.

A write happens if the state is `ARMED` or `WriteEn` is high. In `ARMED`, `WriteEn` is redundant and `Waddr` is ignored.

Protected register: a write to `PROT_ADDR` updates only the bits where `PROT_MASK` is 1. The other bits hold their value, which is 0 after reset.

Read ports:
- Ports are combinational: port i returns `Registers[Raddr_i]`.
- With `Shift` high, port 0 returns `PAIR_LO` and port 1 returns `PAIR_HI`. Ports 2 and up are unaffected.
- With `BYPASS`=1, a read port whose effective address equals the current write address, while a write is in progress, returns the value being written. Protected-register masking applies to the forwarded value.

Flags, evaluated per bit at the edge, highest priority first:
1. `FlagSet` sets the bit.
2. `FlagClr` clears the bit.
3. Load completion clears the bit.
4. Otherwise the bit holds.

Reset and `Start`:
- `Reset_n` low asynchronously clears all registers, `LoadReg`, and `Flags`, and forces `IDLE`.
- `Start` high does the same synchronously. It has priority over `RegSet`, `WriteEn` and `FlagSet`, so no write or flag set occurs in a `Start` cycle.

## Timing
Reset values:
- `IsLoadingReg` = 0.
- `Flags` = 0.
- `DataOut` = 0 for every port, because all registers are 0.

Latency:
- Reads: 0 cycles, combinational from `Raddr`, `Shift` and register state.
- Writes: visible on the read ports after the next rising edge, or in the same cycle when `BYPASS`=1.
- Load: `RegSet` in cycle N, data sampled from `DataIn` at the end of cycle N+1, visible in cycle N+2. `IsLoadingReg` is high in cycle N+1 only, or for longer with back-to-back `RegSet`.

Reset mid-operation:
- `Reset_n` asserted while in `ARMED` aborts the load with no write.
- Deassertion is synchronised externally. The first edge after release is a normal cycle.

## Test plan
- Reset: drive `Reset_n`=0 mid-cycle with all registers preloaded to `0xA5` -> all `DataOut`=0, `Flags`=0 and `IsLoadingReg`=0 immediately, before any clock edge.
- Load: `RegSet` with `Raddr[1]`=3, next cycle `DataIn`=`0x5C` and `WriteEn`=0 -> `IsLoadingReg` is 1 for exactly one cycle; R3=`0x5C` two cycles after `RegSet`; flag cleared.
- Back-to-back loads: `RegSet` on R2, then `RegSet` on R4 with `DataIn`=`0x11`, then `DataIn`=`0x22` -> R2=`0x11`, R4=`0x22`; `IsLoadingReg` high for two cycles.
- Protected register: write `0xFF` to R7 with default mask -> R7=`0x7F`. Then `Shift` with `WriteEn` and `DataIn`=`0x80` -> R7 unchanged at `0x00` if previously cleared; ports 0 and 1 return R6 and R7.
- Bypass: `BYPASS`=1, `NR`=3, write R5=`0x3C` with all three read ports addressing R5 -> all ports show `0x3C` in the same cycle. With `BYPASS`=0 they show the old value until the next edge.
- Priority: `Start`, `WriteEn` and `FlagSet`=1 in the same cycle -> all registers 0, `Flags`=0. `FlagSet` and `FlagClr` both 1 on one bit -> that flag is 1.

Source files
------------

// File: rtl/regfile_gen2.sv
// regfile_gen2: 2**D x W register file with NR combinational read ports,
// one write port, a two-phase RegSet load FSM, shift-pair mode, a bit-masked
// protected register, optional write-to-read bypass and NF sticky flags.

// One read port: returns the addressed register, or the in-flight write data
// when bypass is enabled and the addresses match.
module regfile_gen2_rdport #(
   parameter int W      = 8,
   parameter int D      = 4,
   parameter int DEPTH  = 16,
   parameter bit BYPASS = 1'b0
) (
   input  logic [DEPTH-1:0][W-1:0] regs,
   input  logic [D-1:0]            addr,
   input  logic                    we,
   input  logic [D-1:0]            waddr,
   input  logic [W-1:0]            wdata,
   output logic [W-1:0]            rdata
);

   // Forward only while a write is actually happening to the same register.
   always_comb begin
      rdata = regs[addr];
      if (BYPASS && we && (addr == waddr))
         rdata = wdata;
   end

endmodule

module regfile_gen2 #(
   parameter int           W         = 8,
   parameter int           D         = 4,
   parameter int           NR        = 2,
   parameter int           NF        = 1,
   parameter int           PAIR_LO   = 6,
   parameter int           PAIR_HI   = 7,
   parameter int           PROT_ADDR = 7,
   parameter logic [W-1:0] PROT_MASK = {1'b0, {W-1{1'b1}}},
   parameter bit           BYPASS    = 1'b0
) (
   input  logic            Clk,
   input  logic            Reset_n,
   input  logic            Start,
   input  logic            RegSet,
   input  logic            WriteEn,
   input  logic            Shift,
   input  logic [NF-1:0]   FlagSet,
   input  logic [NF-1:0]   FlagClr,
   input  logic [NR*D-1:0] Raddr,
   input  logic [D-1:0]    Waddr,
   input  logic [W-1:0]    DataIn,
   output logic            IsLoadingReg,
   output logic [NF-1:0]   Flags,
   output logic [NR*W-1:0] DataOut
);

   localparam int           DEPTH  = 2 ** D;
   localparam logic [D-1:0] PLO    = D'(PAIR_LO);
   localparam logic [D-1:0] PHI    = D'(PAIR_HI);
   localparam logic [D-1:0] PROT_A = D'(PROT_ADDR);

   typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_t;

   state_t                   state, next_state;
   logic [D-1:0]             load_reg;
   logic [DEPTH-1:0][W-1:0]  regs;

   logic                     armed;
   logic                     we;
   logic [D-1:0]             waddr;
   logic [W-1:0]             wdata;

   // Next-state: RegSet (re)arms, otherwise an armed cycle always returns to IDLE.
   always_comb begin
      next_state   = state;
      armed        = (state == ARMED);
      IsLoadingReg = armed;
      if (RegSet)
         next_state = ARMED;
      else if (armed)
         next_state = IDLE;
   end

   // State register; Start behaves like a synchronous reset.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         state <= IDLE;
      else if (Start)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Load target: shift mode always loads the pair's high register.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         load_reg <= '0;
      else if (Start)
         load_reg <= '0;
      else if (RegSet)
         load_reg <= Shift ? PHI : Raddr[D +: D];
   end

   // Write address priority: shift pair, pending load, then the normal port.
   // The protected register only takes the mask bits; the rest keep their value.
   always_comb begin
      we    = armed | WriteEn;
      waddr = Shift ? PHI : (armed ? load_reg : Waddr);
      wdata = DataIn;
      if (waddr == PROT_A)
         wdata = (regs[PROT_A] & ~PROT_MASK) | (DataIn & PROT_MASK);
   end

   // Register array update.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         regs <= '0;
      else if (Start)
         regs <= '0;
      else if (we)
         regs[waddr] <= wdata;
   end

   // Sticky flags: set beats clear beats load-completion clear.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         Flags <= '0;
      else if (Start)
         Flags <= '0;
      else begin
         for (int f = 0; f < NF; f++) begin
            if (FlagSet[f])
               Flags[f] <= 1'b1;
            else if (FlagClr[f])
               Flags[f] <= 1'b0;
            else if (armed)
               Flags[f] <= 1'b0;
         end
      end
   end

   // Read ports; in shift mode ports 0/1 present the low/high pair.
   for (genvar i = 0; i < NR; i++) begin : g_rd
      logic [D-1:0] ra;
      assign ra = (Shift && i == 0) ? PLO :
                  (Shift && i == 1) ? PHI : Raddr[i*D +: D];

      regfile_gen2_rdport #(
         .W      (W),
         .D      (D),
         .DEPTH  (DEPTH),
         .BYPASS (BYPASS)
      ) u_rd (
         .regs  (regs),
         .addr  (ra),
         .we    (we),
         .waddr (waddr),
         .wdata (wdata),
         .rdata (DataOut[i*W +: W])
      );
   end

endmodule

// File: tb/tb_regfile_gen2.sv
// Randomized + directed bench for regfile_gen2: two instances (bypass off/on)
// driven by the same stimulus and checked against an array-based model.
module tb_regfile_gen2;

   localparam int W = 8, D = 4, NR = 3, NF = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, regset, wen, shift;
   logic [NF-1:0] fset, fclr;
   logic [D-1:0]  ra [NR];
   logic [NR*D-1:0] raddr;
   logic [D-1:0]  waddr;
   logic [W-1:0]  din;
   logic          ld0, ld1;
   logic [NF-1:0] flg0, flg1;
   logic [NR*W-1:0] dout0, dout1;

   int n_cmp = 0, n_err = 0;

   // reference model state
   logic [W-1:0]  m_reg [16];
   bit            m_armed;
   logic [D-1:0]  m_load;
   logic [NF-1:0] m_flags;

   assign raddr = {ra[2], ra[1], ra[0]};

   always #5 clk = ~clk;

   regfile_gen2 #(.W(W), .D(D), .NR(NR), .NF(NF), .BYPASS(1'b0)) u_dut0 (
      .Clk(clk), .Reset_n(rst_n), .Start(start), .RegSet(regset),
      .WriteEn(wen), .Shift(shift), .FlagSet(fset), .FlagClr(fclr),
      .Raddr(raddr), .Waddr(waddr), .DataIn(din),
      .IsLoadingReg(ld0), .Flags(flg0), .DataOut(dout0));

   regfile_gen2 #(.W(W), .D(D), .NR(NR), .NF(NF), .BYPASS(1'b1)) u_dut1 (
      .Clk(clk), .Reset_n(rst_n), .Start(start), .RegSet(regset),
      .WriteEn(wen), .Shift(shift), .FlagSet(fset), .FlagClr(fclr),
      .Raddr(raddr), .Waddr(waddr), .DataIn(din),
      .IsLoadingReg(ld1), .Flags(flg1), .DataOut(dout1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic m_clear();
      for (int r = 0; r < 16; r++) m_reg[r] = '0;
      m_armed = 0;
      m_load  = '0;
      m_flags = '0;
   endtask

   // Model's view of the write happening this cycle.
   function automatic bit m_we();
      return m_armed || wen;
   endfunction

   function automatic logic [D-1:0] m_wa();
      if (shift) return 4'd7;
      if (m_armed) return m_load;
      return waddr;
   endfunction

   function automatic logic [W-1:0] m_wd();
      if (m_wa() == 4'd7) return (m_reg[7] & 8'h80) | (din & 8'h7F);
      return din;
   endfunction

   function automatic logic [W-1:0] m_rd(input int p, input bit byp);
      logic [D-1:0] a;
      a = ra[p];
      if (shift && p == 0) a = 4'd6;
      if (shift && p == 1) a = 4'd7;
      if (byp && m_we() && a == m_wa()) return m_wd();
      return m_reg[a];
   endfunction

   task automatic m_edge();
      if (start) begin
         m_clear();
      end else begin
         logic [D-1:0] a;
         logic [W-1:0] d;
         bit           w;
         a = m_wa(); d = m_wd(); w = m_we();
         if (w) m_reg[a] = d;
         for (int f = 0; f < NF; f++) begin
            if (fset[f]) m_flags[f] = 1'b1;
            else if (fclr[f]) m_flags[f] = 1'b0;
            else if (m_armed) m_flags[f] = 1'b0;
         end
         if (regset) begin
            m_load  = shift ? 4'd7 : ra[1];
            m_armed = 1;
         end else begin
            m_armed = 0;
         end
      end
   endtask

   task automatic check_all();
      for (int p = 0; p < NR; p++) begin
         chk($sformatf("rd0_p%0d", p), dout0[p*W +: W], m_rd(p, 0));
         chk($sformatf("rd1_p%0d", p), dout1[p*W +: W], m_rd(p, 1));
      end
      chk("loading0", ld0, m_armed);
      chk("loading1", ld1, m_armed);
      chk("flags0", flg0, m_flags);
      chk("flags1", flg1, m_flags);
   endtask

   // One clock cycle: drive at negedge, check mid-cycle, clock, update model.
   task automatic cyc(input bit st, input bit rs, input bit we_i, input bit sh,
                      input logic [NF-1:0] fs, input logic [NF-1:0] fc,
                      input logic [D-1:0] a0, input logic [D-1:0] a1, input logic [D-1:0] a2,
                      input logic [D-1:0] wa, input logic [W-1:0] d);
      start = st; regset = rs; wen = we_i; shift = sh; fset = fs; fclr = fc;
      ra[0] = a0; ra[1] = a1; ra[2] = a2; waddr = wa; din = d;
      #1;
      check_all();
      @(posedge clk);
      m_edge();
      @(negedge clk);
   endtask

   task automatic idle(input logic [D-1:0] a0, input logic [D-1:0] a1);
      cyc(0, 0, 0, 0, '0, '0, a0, a1, 4'd0, 4'd0, 8'h00);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 0; regset = 0; wen = 0; shift = 0; fset = '0; fclr = '0;
      ra[0] = '0; ra[1] = '0; ra[2] = '0; waddr = '0; din = '0;
      m_clear();
      #12;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      // Load: IsLoadingReg one cycle, R3 written without WriteEn, flag cleared.
      cyc(0, 1, 0, 0, 2'b01, '0, 4'd0, 4'd3, 4'd0, 4'd0, 8'h00);
      chk("load_armed", ld0, 1'b1);
      cyc(0, 0, 0, 0, '0, '0, 4'd3, 4'd3, 4'd3, 4'd9, 8'h5C);
      chk("load_done", ld0, 1'b0);
      chk("load_r3", dout0[0 +: W], 8'h5C);
      chk("load_flag", flg0, 2'b00);
      chk("load_r9", m_reg[9], 8'h00);

      // Back-to-back loads.
      cyc(0, 1, 0, 0, '0, '0, 4'd0, 4'd2, 4'd0, 4'd0, 8'h00);
      cyc(0, 1, 0, 0, '0, '0, 4'd0, 4'd4, 4'd0, 4'd0, 8'h11);
      chk("b2b_armed", ld0, 1'b1);
      cyc(0, 0, 0, 0, '0, '0, 4'd2, 4'd4, 4'd0, 4'd0, 8'h22);
      chk("b2b_r2", dout0[0 +: W], 8'h11);
      chk("b2b_r4", dout0[W +: W], 8'h22);
      chk("b2b_idle", ld0, 1'b0);

      // Protected register masking and shift-pair reads.
      cyc(0, 0, 1, 0, '0, '0, 4'd7, 4'd0, 4'd0, 4'd7, 8'hFF);
      chk("prot_r7", dout0[0 +: W], 8'h7F);
      cyc(1, 0, 0, 0, '0, '0, 4'd7, 4'd0, 4'd0, 4'd0, 8'h00);
      cyc(0, 0, 1, 0, '0, '0, 4'd0, 4'd0, 4'd0, 4'd6, 8'h33);
      cyc(0, 0, 1, 1, '0, '0, 4'd0, 4'd0, 4'd0, 4'd2, 8'h80);
      chk("shift_p0", dout0[0 +: W], 8'h33);
      chk("shift_p1", dout0[W +: W], 8'h00);

      // Bypass: same-cycle visibility only on the bypass instance.
      start = 0; regset = 0; wen = 1; shift = 0; fset = '0; fclr = '0;
      ra[0] = 4'd5; ra[1] = 4'd5; ra[2] = 4'd5; waddr = 4'd5; din = 8'h3C;
      #1;
      chk("byp_on", dout1, {3{8'h3C}});
      chk("byp_off", dout0, {3{8'h00}});
      cyc(0, 0, 1, 0, '0, '0, 4'd5, 4'd5, 4'd5, 4'd5, 8'h3C);
      chk("byp_after", dout0, {3{8'h3C}});

      // Priority: Start beats write and flag set; set beats clear.
      cyc(1, 1, 1, 0, 2'b11, '0, 4'd5, 4'd5, 4'd5, 4'd5, 8'hEE);
      chk("start_reg", dout0[0 +: W], 8'h00);
      chk("start_flags", flg0, 2'b00);
      chk("start_idle", ld0, 1'b0);
      cyc(0, 0, 0, 0, 2'b01, 2'b11, 4'd5, 4'd5, 4'd5, 4'd0, 8'h00);
      chk("set_over_clr", flg0, 2'b01);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 1) == 1), ($urandom_range(0, 4) == 0),
             NF'($urandom_range(0, 7) == 0 ? $urandom : 0),
             NF'($urandom_range(0, 3) == 0 ? $urandom : 0),
             D'($urandom), D'($urandom), D'($urandom), D'($urandom), W'($urandom));
      end

      // Async reset mid-cycle, while armed with flags set and registers preloaded.
      for (int r = 0; r < 16; r++)
         cyc(0, 0, 1, 0, '0, '0, 4'd0, 4'd0, 4'd0, D'(r), 8'hA5);
      cyc(0, 1, 0, 0, 2'b11, '0, 4'd1, 4'd2, 4'd7, 4'd0, 8'h00);
      chk("pre_rst_armed", ld0, 1'b1);
      chk("pre_rst_r1", dout0[0 +: W], 8'hA5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_dout0", dout0, '0);
      chk("rst_dout1", dout1, '0);
      chk("rst_flags", flg0, '0);
      chk("rst_loading", ld0, 1'b0);
      m_clear();
      @(negedge clk);
      rst_n = 1'b1;
      idle(4'd2, 4'd7);
      idle(4'd2, 4'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
